// File: rtl/ram_pkg.sv
// ram_pkg
//  Shared types and helpers for the arbitrated word memory.
//  Contents:
//    state_t         controller state (ST_CLEAR while zero-filling, ST_RUN when serving)
//    PRIORITY_RR     round-robin arbitration selector
//    PRIORITY_FIXED  fixed arbitration selector (lowest index wins)
//    clog2()         ceiling log2, usable in parameter expressions
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int PRIORITY_RR    = 0;
    localparam int PRIORITY_FIXED = 1;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//  Picks at most one requester per cycle, combinationally.
//  Round-robin mode searches from the port after the last winner; fixed
//  mode always prefers the lowest requesting index.
//  Ports:
//    clk       in   clock
//    reset_n   in   asynchronous active-low reset
//    enable_i  in   arbitration allowed this cycle (no grant when low)
//    req_i     in   NUM_PORTS request vector
//    grant_o   out  NUM_PORTS one-hot or zero grant
module rr_arbiter
    import ram_pkg::*;
#(
    parameter int NUM_PORTS     = 2,
    parameter int PRIORITY_MODE = PRIORITY_RR
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable_i,
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] grant_o
);

    localparam int PTR_W = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1;

    logic [PTR_W-1:0]     lastGrant_q;
    logic [PTR_W-1:0]     lastGrant_d;
    logic [NUM_PORTS-1:0] aboveMask;
    logic [NUM_PORTS-1:0] reqAbove;

    function automatic logic [NUM_PORTS-1:0] pickLowest(input logic [NUM_PORTS-1:0] v);
        logic [NUM_PORTS-1:0] oneHot;
        oneHot = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (v[i] && (oneHot == '0)) begin
                oneHot[i] = 1'b1;
            end
        end
        return oneHot;
    endfunction

    // Round-robin as a two-pass priority search: requesters above the last
    // winner are tried first, and only if none exist does the search wrap
    // around to the lowest requester overall.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            aboveMask[i] = (i > int'(lastGrant_q));
        end
        reqAbove = req_i & aboveMask;
    end

    // Grant selection and pointer next-state; the pointer only moves when
    // a grant is actually issued.
    always_comb begin
        grant_o     = '0;
        lastGrant_d = lastGrant_q;
        if (enable_i) begin
            if (PRIORITY_MODE == PRIORITY_FIXED) begin
                grant_o = pickLowest(req_i);
            end else if (|reqAbove) begin
                grant_o = pickLowest(reqAbove);
            end else begin
                grant_o = pickLowest(req_i);
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_o[i]) begin
                lastGrant_d = PTR_W'(i);
            end
        end
    end

    // The pointer resets to the highest port so port 0 is first in line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lastGrant_q <= PTR_W'(NUM_PORTS - 1);
        end else begin
            lastGrant_q <= lastGrant_d;
        end
    end

endmodule

// File: rtl/arbitrated_ram.sv
// arbitrated_ram
//  Multi-port word memory: NUM_PORTS requesters share one single-port
//  synchronous array through rr_arbiter. After reset an optional zero-fill
//  pass clears every word before any request is served.
//  Ports:
//    clk          in   clock
//    reset_n      in   asynchronous active-low reset
//    req_i        in   per-port request
//    write_i      in   per-port 1 = write, 0 = read
//    addr_i       in   packed per-port addresses (port p at [p*ADDR_WIDTH +: ADDR_WIDTH])
//    value_i      in   packed per-port write data (same packing)
//    grant_o      out  one-hot or zero; access accepted this cycle
//    rvalid_o     out  one-cycle pulse per port; value_o holds that port's read data
//    value_o      out  registered read data, shared by all ports
//    err_o        out  one-cycle pulse per port; granted access was out of range
//    init_busy_o  out  high while the zero-fill runs
module arbitrated_ram
    import ram_pkg::*;
#(
    parameter int MEM_SIZE      = 4096,
    parameter int WORD_SIZE     = 20,
    parameter int ADDR_WIDTH    = 12,
    parameter int NUM_PORTS     = 2,
    parameter int PRIORITY_MODE = PRIORITY_RR,
    parameter int ZERO_ON_RESET = 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_PORTS-1:0]            req_i,
    input  logic [NUM_PORTS-1:0]            write_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_PORTS*WORD_SIZE-1:0]  value_i,
    output logic [NUM_PORTS-1:0]            grant_o,
    output logic [NUM_PORTS-1:0]            rvalid_o,
    output logic [WORD_SIZE-1:0]            value_o,
    output logic [NUM_PORTS-1:0]            err_o,
    output logic                            init_busy_o
);

    localparam int                  IDX_W     = (MEM_SIZE > 1) ? clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(MEM_SIZE - 1);

    state_t                 state_q;
    state_t                 state_d;
    logic [IDX_W-1:0]       clearCnt_q;
    logic [IDX_W-1:0]       clearCnt_d;

    logic [NUM_PORTS-1:0]   grant;
    logic                   anyGrant;
    logic [ADDR_WIDTH-1:0]  selAddr;
    logic [WORD_SIZE-1:0]   selData;
    logic                   selWrite;
    logic                   inRange;
    logic [IDX_W-1:0]       memIdx;
    logic [WORD_SIZE-1:0]   readWord;

    logic [NUM_PORTS-1:0]   rvalid_q;
    logic [NUM_PORTS-1:0]   err_q;
    logic [WORD_SIZE-1:0]   value_q;

    logic [WORD_SIZE-1:0]   mem [MEM_SIZE];

    rr_arbiter #(
        .NUM_PORTS     (NUM_PORTS),
        .PRIORITY_MODE (PRIORITY_MODE)
    ) u_arbiter (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable_i (state_q == ST_RUN),
        .req_i    (req_i),
        .grant_o  (grant)
    );

    // Select the winning port's command. Non-granted ports' buses are
    // never looked at, so they may carry anything.
    always_comb begin
        selAddr  = '0;
        selData  = '0;
        selWrite = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                selAddr  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                selData  = value_i[i*WORD_SIZE +: WORD_SIZE];
                selWrite = write_i[i];
            end
        end
    end

    // The range check uses one extra bit so an address equal to MEM_SIZE
    // is caught even when MEM_SIZE is a power of two.
    always_comb begin
        anyGrant = |grant;
        inRange  = ({1'b0, selAddr} < MEM_LIMIT);
        memIdx   = selAddr[IDX_W-1:0];
        readWord = inRange ? mem[memIdx] : '0;
    end

    // Controller next state: CLEAR walks every address once, then hands
    // over to RUN for good.
    always_comb begin
        state_d    = state_q;
        clearCnt_d = clearCnt_q;
        case (state_q)
            ST_CLEAR: begin
                clearCnt_d = clearCnt_q + 1'b1;
                if (clearCnt_q == LAST_IDX) begin
                    state_d    = ST_RUN;
                    clearCnt_d = '0;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= (ZERO_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clearCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            clearCnt_q <= clearCnt_d;
        end
    end

    // Storage has no reset. The single write port is shared by the
    // zero-fill and granted writes; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[clearCnt_q] <= '0;
        end else if (anyGrant && selWrite && inRange) begin
            mem[memIdx] <= selData;
        end
    end

    // Response registers: rvalid and err land one cycle after the grant
    // edge; value_o only changes on a granted read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid_q <= '0;
            err_q    <= '0;
            value_q  <= '0;
        end else begin
            rvalid_q <= (anyGrant && !selWrite) ? grant : '0;
            err_q    <= (anyGrant && !inRange) ? grant : '0;
            if (anyGrant && !selWrite) begin
                value_q <= readWord;
            end
        end
    end

    assign grant_o     = grant;
    assign rvalid_o    = rvalid_q;
    assign err_o       = err_q;
    assign value_o     = value_q;
    assign init_busy_o = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_arbitrated_ram.sv
// tb_arbitrated_ram
//  Drives a 16-word, 2-port round-robin instance with directed and random
//  traffic and compares it every cycle against a behavioural model; a
//  second fixed-priority instance gets a short directed sequence.
module tb_arbitrated_ram;

    localparam int MEM = 16;
    localparam int AW  = 5;
    localparam int WS  = 20;
    localparam int NP  = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NP-1:0]    req;
    logic [NP-1:0]    write;
    logic [NP*AW-1:0] addr;
    logic [NP*WS-1:0] value;
    logic [NP-1:0]    grant_o;
    logic [NP-1:0]    rvalid_o;
    logic [WS-1:0]    value_o;
    logic [NP-1:0]    err_o;
    logic             init_busy_o;

    logic [NP-1:0]    reqF;
    logic [NP*AW-1:0] addrF;
    logic [NP-1:0]    grantF;
    logic [NP-1:0]    rvalidF;
    logic [WS-1:0]    valueF;
    logic [NP-1:0]    errF;
    logic             busyF;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [WS-1:0] modelMem [MEM];
    int            clearLeft;
    int            lastGrant;
    logic [NP-1:0] expRvalid;
    logic [NP-1:0] expErr;
    logic [WS-1:0] expValue;

    always #5 clk = ~clk;

    arbitrated_ram #(
        .MEM_SIZE(MEM), .WORD_SIZE(WS), .ADDR_WIDTH(AW), .NUM_PORTS(NP),
        .PRIORITY_MODE(0), .ZERO_ON_RESET(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req_i(req), .write_i(write),
        .addr_i(addr), .value_i(value), .grant_o(grant_o), .rvalid_o(rvalid_o),
        .value_o(value_o), .err_o(err_o), .init_busy_o(init_busy_o)
    );

    arbitrated_ram #(
        .MEM_SIZE(MEM), .WORD_SIZE(WS), .ADDR_WIDTH(AW), .NUM_PORTS(NP),
        .PRIORITY_MODE(1), .ZERO_ON_RESET(1)
    ) dutFix (
        .clk(clk), .reset_n(reset_n), .req_i(reqF), .write_i(2'b00),
        .addr_i(addrF), .value_i('0), .grant_o(grantF), .rvalid_o(rvalidF),
        .value_o(valueF), .err_o(errF), .init_busy_o(busyF)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle's worth of inputs just after a rising edge.
    task automatic applyStimulus(input logic [NP-1:0] r, input logic [NP-1:0] w,
                                 input int a0, input int a1,
                                 input logic [WS-1:0] v0, input logic [WS-1:0] v1);
        @(posedge clk);
        #1;
        req   = r;
        write = w;
        addr  = {AW'(a1), AW'(a0)};
        value = {v1, v0};
    endtask

    // Count consecutive falling edges with init_busy_o high (bounded).
    task automatic countBusy(output int n);
        n = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (init_busy_o) n++;
            else break;
        end
    endtask

    function automatic int randAddr();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(MEM, 31));
        return int'($urandom_range(0, MEM - 1));
    endfunction

    // Reference model and per-cycle comparison. At each falling edge the
    // registered outputs are checked against what the previous edge should
    // have produced, the grant is predicted from the current requests, and
    // the effect of the coming rising edge is applied to the model.
    always @(negedge clk) begin : compareProc
        int            p;
        int            a;
        int            c;
        logic [NP-1:0] expGrant;
        if (!reset_n) begin
            checkOutput("reset_grant", grant_o, 0);
            checkOutput("reset_rvalid", rvalid_o, 0);
            checkOutput("reset_err", err_o, 0);
            checkOutput("reset_value", value_o, 0);
            clearLeft = MEM;
            lastGrant = NP - 1;
            expRvalid = '0;
            expErr    = '0;
            expValue  = '0;
        end else begin
            checkOutput("init_busy", init_busy_o, clearLeft > 0);
            checkOutput("rvalid", rvalid_o, expRvalid);
            checkOutput("err", err_o, expErr);
            checkOutput("value", value_o, expValue);
            expGrant = '0;
            p = -1;
            if (clearLeft == 0) begin
                for (int off = 1; off <= NP; off++) begin
                    c = (lastGrant + off) % NP;
                    if (req[c] && p < 0) p = c;
                end
            end
            if (p >= 0) expGrant[p] = 1'b1;
            checkOutput("grant", grant_o, expGrant);
            expRvalid = '0;
            expErr    = '0;
            if (clearLeft > 0) begin
                modelMem[MEM - clearLeft] = '0;
                clearLeft--;
            end else if (p >= 0) begin
                lastGrant = p;
                a = int'(addr[p*AW +: AW]);
                if (write[p]) begin
                    if (a < MEM) modelMem[a] = value[p*WS +: WS];
                    else expErr[p] = 1'b1;
                end else begin
                    expRvalid[p] = 1'b1;
                    if (a < MEM) expValue = modelMem[a];
                    else begin
                        expValue  = '0;
                        expErr[p] = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog timeout at %0t", $time);
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : mainSeq
        int busyCycles;
        reset_n = 1'b0;
        req = '0; write = '0; addr = '0; value = '0;
        reqF = '0; addrF = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Zero-fill lasts exactly MEM cycles, then every word reads 0.
        countBusy(busyCycles);
        checkOutput("clear_cycles", busyCycles, MEM);
        for (int a = 0; a < MEM; a++) begin
            applyStimulus(2'b01, 2'b00, a, 0, '0, '0);
            applyStimulus(2'b00, 2'b00, 0, 0, '0, '0);
            @(negedge clk);
            checkOutput("zero_fill_rvalid", rvalid_o, 2'b01);
            checkOutput("zero_fill_value", value_o, 0);
        end

        // Write then read back on port 0.
        applyStimulus(2'b01, 2'b01, 5, 0, 20'h12345, '0);
        applyStimulus(2'b01, 2'b00, 5, 0, '0, '0);
        applyStimulus(2'b00, 2'b00, 0, 0, '0, '0);
        @(negedge clk);
        checkOutput("wr_rd_rvalid", rvalid_o, 2'b01);
        checkOutput("wr_rd_value", value_o, 20'h12345);

        // Both ports reading continuously; port 0 won last, so port 1 is next.
        applyStimulus(2'b11, 2'b00, 1, 2, '0, '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("rr_grant", grant_o, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k > 0) checkOutput("rr_rvalid", rvalid_o, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        applyStimulus(2'b00, 2'b00, 0, 0, '0, '0);

        // Out-of-range read at exactly MEM, and the last valid address.
        applyStimulus(2'b10, 2'b00, 0, MEM, '0, '0);
        applyStimulus(2'b00, 2'b00, 0, 0, '0, '0);
        @(negedge clk);
        checkOutput("oor_rvalid", rvalid_o, 2'b10);
        checkOutput("oor_err", err_o, 2'b10);
        checkOutput("oor_value", value_o, 0);
        applyStimulus(2'b10, 2'b00, 0, MEM - 1, '0, '0);
        applyStimulus(2'b00, 2'b00, 0, 0, '0, '0);
        @(negedge clk);
        checkOutput("top_addr_err", err_o, 2'b00);
        checkOutput("top_addr_rvalid", rvalid_o, 2'b10);

        // An out-of-range write must not alias onto address 0.
        applyStimulus(2'b01, 2'b01, 0, 0, 20'hABCDE, '0);
        applyStimulus(2'b01, 2'b01, MEM, 0, 20'h11111, '0);
        applyStimulus(2'b00, 2'b00, 0, 0, '0, '0);
        @(negedge clk);
        checkOutput("oor_wr_err", err_o, 2'b01);
        checkOutput("oor_wr_rvalid", rvalid_o, 2'b00);
        applyStimulus(2'b01, 2'b00, 0, 0, '0, '0);
        applyStimulus(2'b00, 2'b00, 0, 0, '0, '0);
        @(negedge clk);
        checkOutput("oor_wr_alias", value_o, 20'hABCDE);

        // Fixed priority: port 1 starves until port 0 drops its request.
        @(posedge clk);
        #1 reqF = 2'b11; addrF = {AW'(2), AW'(1)};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("fix_grant", grantF, 2'b01);
            if (k > 0) checkOutput("fix_rvalid", rvalidF, 2'b01);
        end
        checkOutput("fix_busy", busyF, 0);
        @(posedge clk);
        #1 reqF = 2'b10;
        @(negedge clk);
        checkOutput("fix_grant_p1", grantF, 2'b10);
        @(posedge clk);
        #1 reqF = 2'b00;
        @(negedge clk);
        checkOutput("fix_rvalid_p1", rvalidF, 2'b10);
        checkOutput("fix_err", errF, 0);
        checkOutput("fix_value", valueF, 0);

        // Random traffic, checked by the model every cycle.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(NP'($urandom), NP'($urandom), randAddr(), randAddr(),
                          WS'($urandom), WS'($urandom));
        end

        // Reset in the middle of the zero-fill, with both ports requesting.
        applyStimulus(2'b11, 2'b00, 3, 4, '0, '0);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (7) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        countBusy(busyCycles);
        checkOutput("reclear_cycles", busyCycles, MEM);
        applyStimulus(2'b00, 2'b00, 0, 0, '0, '0);
        applyStimulus(2'b01, 2'b00, 5, 0, '0, '0);
        applyStimulus(2'b00, 2'b00, 0, 0, '0, '0);
        @(negedge clk);
        checkOutput("reclear_value", value_o, 0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
